conv_window_feeder: RTL and testbench

Producer side of the convolution input FIFO. Walks a 3x3 kernel across an IMG_H x IMG_W pixel buffer (valid padding, stride 1) and pushes one {pixel, weight} pair per FIFO write, 9 pairs per output window. It sits between the image/weight SRAMs and the FIFO that conv_calculation drains. Default geometry gives 30x30 = 900 windows, which matches the consumer's finish count.

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_window_feeder_if.sv | 25 ++
 rtl/conv_skid_reg.sv | 38 +++
 rtl/conv_window_feeder.sv | 111 +++++++++++
 tb/tb_conv_window_feeder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: element widths, kernel size,
// default image geometry and the FIFO word layout used by producer and consumer.
package conv_pkg;
    localparam int PIXEL_WIDTH    = 8;
    localparam int WEIGHT_WIDTH   = 8;
    localparam int KERNEL         = 3;
    localparam int IMG_W_DEFAULT  = 32;
    localparam int IMG_H_DEFAULT  = 32;
    localparam int IMG_AW_DEFAULT = 10;

    // FIFO word: pixel in the MSBs, weight in the LSBs
    typedef struct packed {
        logic [PIXEL_WIDTH-1:0]  pixel;
        logic [WEIGHT_WIDTH-1:0] weight;
    } fifo_word_t;
endpackage

// File: rtl/conv_window_feeder_if.sv
// FIFO write port plus image/weight SRAM read ports of the window feeder.
interface conv_window_feeder_if import conv_pkg::*; #(
    parameter int PIXEL_W  = PIXEL_WIDTH,
    parameter int WEIGHT_W = WEIGHT_WIDTH,
    parameter int IMG_AW   = IMG_AW_DEFAULT
);
    logic                         fifo_full;
    logic                         fifo_write;
    logic [PIXEL_W+WEIGHT_W-1:0]  fifo_wdata;
    logic                         img_rd;
    logic [IMG_AW-1:0]            img_addr;
    logic [PIXEL_W-1:0]           img_rdata;
    logic [3:0]                   w_addr;
    logic [WEIGHT_W-1:0]          w_rdata;

    modport master (
        input  fifo_full, img_rdata, w_rdata,
        output fifo_write, fifo_wdata, img_rd, img_addr, w_addr
    );

    modport slave (
        output fifo_full, img_rdata, w_rdata,
        input  fifo_write, fifo_wdata, img_rd, img_addr, w_addr
    );
endinterface

// File: rtl/conv_skid_reg.sv
// One-entry hold register: captures the returning pair when the FIFO is full and
// releases it first once the FIFO can accept a write again.
module conv_skid_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             full,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             hold_valid
);
    logic [WIDTH-1:0] hold_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (full) begin
            if (in_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= in_data;
            end
        end else begin
            hold_valid <= 1'b0;
        end
    end

    // A held pair blocks new reads upstream, so hold and in_valid never coexist
    always_comb begin
        out_valid = (in_valid || hold_valid) && !full;
        out_data  = '0;
        if (out_valid)
            out_data = hold_valid ? hold_data : in_data;
    end
endmodule

// File: rtl/conv_window_feeder.sv
// Walks a 3x3 kernel over the image (valid padding, stride 1) and pushes one
// {pixel, weight} pair per FIFO write, nine pairs per output window.
module conv_window_feeder import conv_pkg::*; #(
    parameter int IMG_W    = IMG_W_DEFAULT,
    parameter int IMG_H    = IMG_H_DEFAULT,
    parameter int PIXEL_W  = PIXEL_WIDTH,
    parameter int WEIGHT_W = WEIGHT_WIDTH,
    parameter int IMG_AW   = IMG_AW_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    conv_window_feeder_if.master   bus,
    output logic                   busy,
    output logic                   done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [1:0]    KMAX = 2'(KERNEL - 1);
    localparam logic [CW-1:0] CMAX = CW'(IMG_W - KERNEL);
    localparam logic [RW-1:0] RMAX = RW'(IMG_H - KERNEL);

    logic [1:0]    state;
    logic [1:0]    kx, ky;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          in_flight;
    logic          hold_valid;
    logic          start_acc;
    logic          rd_issue;
    logic          last_read;

    always_comb begin
        start_acc = (state == IDLE) && start;
        rd_issue  = (state == RUN) && !bus.fifo_full && !hold_valid;
        last_read = rd_issue && (row == RMAX) && (col == CMAX) && (ky == KMAX) && (kx == KMAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_flight <= 1'b0;
        end else begin
            in_flight <= rd_issue;
            case (state)
                IDLE:    if (start) state <= RUN;
                RUN:     if (last_read) state <= DRAIN;
                DRAIN:   if (!in_flight && !hold_valid) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // The final read wraps every counter back to zero, leaving them cleared for the next frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kx  <= '0;
            ky  <= '0;
            col <= '0;
            row <= '0;
        end else if (start_acc) begin
            kx  <= '0;
            ky  <= '0;
            col <= '0;
            row <= '0;
        end else if (rd_issue) begin
            if (kx == KMAX) begin
                kx <= '0;
                if (ky == KMAX) begin
                    ky <= '0;
                    if (col == CMAX) begin
                        col <= '0;
                        row <= (row == RMAX) ? '0 : row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end else begin
                    ky <= ky + 2'd1;
                end
            end else begin
                kx <= kx + 2'd1;
            end
        end
    end

    always_comb begin
        bus.img_rd   = rd_issue;
        bus.img_addr = IMG_AW'((32'(row) + 32'(ky)) * 32'(IMG_W) + 32'(col) + 32'(kx));
        bus.w_addr   = 4'(ky) * 4'(KERNEL) + 4'(kx);
        busy         = (state == RUN) || (state == DRAIN);
        done         = (state == DONE);
    end

    conv_skid_reg #(
        .WIDTH(PIXEL_W + WEIGHT_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_flight),
        .in_data   ({bus.img_rdata, bus.w_rdata}),
        .full      (bus.fifo_full),
        .out_valid (bus.fifo_write),
        .out_data  (bus.fifo_wdata),
        .hold_valid(hold_valid)
    );
endmodule

// File: tb/tb_conv_window_feeder.sv
// Scoreboard bench for conv_window_feeder: expected reads and FIFO words come from
// a nested-loop window walk over random image/weight memories.
module tb_conv_window_feeder;
    import conv_pkg::*;

    localparam int W     = 32;
    localparam int H     = 32;
    localparam int AW    = 10;
    localparam int NPAIR = (H - 2) * (W - 2) * 9;
    localparam int LIMIT = 40000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy, done;

    always #5 clk = ~clk;

    conv_window_feeder_if #(.PIXEL_W(8), .WEIGHT_W(8), .IMG_AW(AW)) bus ();

    conv_window_feeder #(
        .IMG_W(W), .IMG_H(H), .PIXEL_W(8), .WEIGHT_W(8), .IMG_AW(AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .bus  (bus),
        .busy (busy),
        .done (done)
    );

    logic [7:0] img_mem [1024];
    logic [7:0] w_mem   [16];

    // Synchronous-read SRAM models
    always @(posedge clk) begin
        if (bus.img_rd) begin
            bus.img_rdata <= img_mem[bus.img_addr];
            bus.w_rdata   <= w_mem[bus.w_addr];
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int frame_wr = 0;
    int first_rd = -1;
    int last_wr  = 0;
    logic [15:0] exp_q [$];
    logic [13:0] exp_a [$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        for (int r = 0; r < H - 2; r++)
            for (int c = 0; c < W - 2; c++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++) begin
                        int a;
                        int wa;
                        a  = (r + ky) * W + c + kx;
                        wa = ky * 3 + kx;
                        exp_q.push_back({img_mem[a], w_mem[wa]});
                        exp_a.push_back({10'(a), 4'(wa)});
                    end
    endtask

    // Monitor: every issued read and every FIFO write is popped against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (bus.img_rd) begin
                logic [13:0] ea;
                if (first_rd < 0) first_rd = cyc;
                check("rd_while_full", bus.fifo_full, 0);
                if (exp_a.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_read: actual addr=%0d required no read", bus.img_addr);
                end else begin
                    ea = exp_a.pop_front();
                    check("img_addr", bus.img_addr, ea[13:4]);
                    check("w_addr", bus.w_addr, ea[3:0]);
                end
            end
            if (bus.fifo_write) begin
                frame_wr++;
                last_wr = cyc;
                check("write_while_full", bus.fifo_full, 0);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_write: actual data=%0h required no write", bus.fifo_wdata);
                end else begin
                    check("fifo_wdata", bus.fifo_wdata, exp_q.pop_front());
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_fifo_write"}, bus.fifo_write, 0);
        check({tag, "_fifo_wdata"}, bus.fifo_wdata, 0);
        check({tag, "_img_rd"}, bus.img_rd, 0);
        check({tag, "_img_addr"}, bus.img_addr, 0);
        check({tag, "_w_addr"}, bus.w_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_hold_valid"}, dut.u_skid.hold_valid, 0);
    endtask

    // mode 0: free-running + stray start at write 100; 1: random full + 5-cycle burst;
    // 2: free-running, reset mid-frame with a held pair; 3: plain free-running
    task automatic run_frame(input int mode);
        bit fin = 0, sfired = 0, armed = 0, bp_done = 0, prev_rd;
        int bp_left = 0, dones = 0;
        exp_q.delete();
        exp_a.delete();
        push_frame();
        frame_wr = 0;
        first_rd = -1;
        @(posedge clk); #1;
        start = 1'b1;
        bus.fifo_full = 1'b0;
        @(negedge clk);
        check("busy_during_start", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy, 1);
        for (int n = 0; n < LIMIT && !fin; n++) begin
            prev_rd = bus.img_rd;
            if (done) begin
                dones++;
                check("busy_at_done", busy, 0);
                check("writes_at_done", frame_wr, NPAIR);
                fin = 1;
            end else begin
                @(posedge clk); #1;
                start = 1'b0;
                bus.fifo_full = 1'b0;
                case (mode)
                    0: if (!sfired && frame_wr >= 100) begin
                           start = 1'b1;
                           sfired = 1;
                       end
                    1: if (bp_left > 0) begin
                           check("hold_during_bp", dut.u_skid.hold_valid, 1);
                           bus.fifo_full = 1'b1;
                           bp_left--;
                       end else if (!bp_done && frame_wr >= 500 && prev_rd) begin
                           bus.fifo_full = 1'b1;
                           bp_left = 4;
                           bp_done = 1;
                       end else begin
                           bus.fifo_full = 1'($urandom_range(0, 1));
                       end
                    2: if (armed) begin
                           check("hold_before_reset", dut.u_skid.hold_valid, 1);
                           reset = 1'b0;
                           #1;
                           check_idle_outputs("midreset");
                           fin = 1;
                       end else if (frame_wr >= 4000 && prev_rd) begin
                           bus.fifo_full = 1'b1;
                           armed = 1;
                       end
                    default: ;
                endcase
                if (!fin) @(negedge clk);
            end
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL frame_timeout: mode=%0d actual writes=%0d required %0d", mode, frame_wr, NPAIR);
        end
        if (mode == 2) begin
            bus.fifo_full = 1'b0;
            exp_q.delete();
            exp_a.delete();
            repeat (2) @(posedge clk);
            #1 reset = 1'b1;
        end else begin
            repeat (5) begin
                @(negedge clk);
                if (done) dones++;
            end
            check("done_pulses", dones, 1);
            check("frame_writes", frame_wr, NPAIR);
            check("sb_leftover", exp_q.size(), 0);
            if (mode == 0) check("first_read_to_last_write", last_wr - first_rd, NPAIR);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) img_mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) w_mem[i] = 8'($urandom);
        bus.fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        run_frame(0);
        run_frame(1);
        run_frame(2);
        @(negedge clk);
        check_idle_outputs("after_reset");
        run_frame(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
